sig_buf: RTL and testbench
==========================

SIG_BUF -- requirements
Module: sig_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-1, level at or above which afull asserts.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sig_in_vld  input  1  upstream valid-only strobe; no backpressure.
REQ-007 SHALL have port sig_in  input  WIDTH  upstream data, sampled when sig_in_vld=1.
REQ-008 SHALL have port sig_out_vld  output  1  downstream valid.
REQ-009 SHALL have port sig_out_rdy  input  1  downstream ready.
REQ-010 SHALL have port sig_out  output  WIDTH  head-of-buffer data.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port afull  output  1  level >= AFULL_LVL, for upstream throttling.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.
REQ-014 SHALL have port ovf_clr  input  1  synchronous clear of ovf (and ovf_cnt when compiled in).

Function
REQ-015 SHALL write sig_in into the tail entry in any cycle with sig_in_vld=1, unless the write is dropped per REQ-019.
REQ-016 SHALL pop the head entry in any cycle with sig_out_vld=1 and sig_out_rdy=1.
REQ-017 SHALL drive sig_out_vld = (level != 0) and sig_out = head entry; sig_out SHALL be 0 whenever level = 0.
REQ-018 SHALL provide first-word fall-through: data written in cycle N is on sig_out with sig_out_vld=1 in cycle N+1 when the buffer was empty.
REQ-019 SHALL drop a write when level = DEPTH and no pop occurs in the same cycle; ovf SHALL be set the following cycle.
REQ-020 SHALL accept a write when level = DEPTH and a pop occurs in the same cycle; level stays at DEPTH.
REQ-021 SHALL leave level unchanged on a simultaneous write and pop at 0 < level < DEPTH.
REQ-022 SHALL NOT pop while empty; a write into an empty buffer with sig_out_rdy=1 SHALL NOT pass through in the same cycle.
REQ-023 SHALL use read and write pointers of $clog2(DEPTH)+1 bits with natural wrap; full = MSBs differ and the remaining bits are equal.
REQ-024 SHALL register level, and SHALL register afull so that it is exactly (level >= AFULL_LVL) in every cycle.
REQ-025 SHALL let set win over clear when ovf_clr=1 coincides with a dropped write.
REQ-026 SHALL preserve data order; no entry is duplicated or reordered across pointer wrap.

Reset
REQ-027 SHALL, on rstn=0, asynchronously clear the pointers, level, afull, ovf and ovf_cnt, which forces sig_out_vld=0 and sig_out=0.
REQ-028 SHALL leave storage entries unreset; they are not observable while empty.
REQ-029 SHALL discard all contents on reset mid-operation; the first write after rstn rises SHALL be the head.

Configuration
REQ-030 SHALL, with SIG_BUF_OVF_CNT_EN defined, add port ovf_cnt  output  16  count of dropped writes, saturating at 16'hFFFF and cleared by ovf_clr (increment wins over clear).
REQ-031 SHALL, without SIG_BUF_OVF_CNT_EN, omit the ovf_cnt port and the counter; all other behaviour is unchanged.

Structure
REQ-032 SHALL take the shared constant OVF_CNT_W=16 and a level-width helper function from package sig_pkg.
REQ-033 SHALL place storage in sub-module sig_buf_mem (register array, one write port, one asynchronous read port); pointer, level and flag logic stays in sig_buf.

Verification
REQ-034 Bench SHALL cover: write 0x1 with rdy=1, empty buffer -> sig_out_vld=1, sig_out=0x1 next cycle, then empty, level back to 0.
REQ-035 Bench SHALL cover: DEPTH=4, rdy=0, write 0xA,0xB,0xC,0xD,0xE -> level=4, afull=1, ovf=1; drain order 0xA..0xD; 0xE is lost.
REQ-036 Bench SHALL cover: full buffer, write 0x5 with rdy=1 -> accepted, level stays 4, ovf stays 0; 0x5 drains last.
REQ-037 Bench SHALL cover: 1000 cycles of random vld/rdy, rdy duty cycle >= vld duty cycle -> scoreboard matches in order, no ovf, pointers wrap at least 100 times.
REQ-038 Bench SHALL cover: rstn pulsed low with level=3 -> sig_out_vld=0, level=0, sig_out=0 immediately; next write is the head.
REQ-039 Bench SHALL cover, with SIG_BUF_OVF_CNT_EN: 3 dropped writes, then ovf_clr together with a 4th drop -> ovf_cnt=3, then 1, ovf=1.

Source files
------------

// File: rtl/sig_pkg.sv
// Shared constants and helpers for the sig_buf elastic buffer.
package sig_pkg;

   localparam int OVF_CNT_W = 16;

   // Occupancy spans 0..depth inclusive, so it needs one bit more than an address.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sig_buf_if.sv
// Upstream valid-only strobe and downstream valid/ready handshake of sig_buf.
interface sig_buf_if #(
   parameter int WIDTH = 1
) ();

   logic             sig_in_vld;
   logic [WIDTH-1:0] sig_in;
   logic             sig_out_vld;
   logic             sig_out_rdy;
   logic [WIDTH-1:0] sig_out;

   modport master (
      output sig_in_vld, sig_in, sig_out_rdy,
      input  sig_out_vld, sig_out
   );

   modport slave (
      input  sig_in_vld, sig_in, sig_out_rdy,
      output sig_out_vld, sig_out
   );

endinterface

// File: rtl/sig_buf_mem.sv
// Unreset register-array storage: one synchronous write port, one asynchronous read port.
module sig_buf_mem import sig_pkg::*; #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sig_buf.sv
// First-word fall-through buffer with level, almost-full and sticky overflow reporting.
// Defining SIG_BUF_OVF_CNT_EN adds the saturating dropped-write counter port ovf_cnt.
module sig_buf import sig_pkg::*; #(
   parameter int WIDTH     = 1,
   parameter int DEPTH     = 4,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   sig_buf_if.slave                   bus,
   output logic [lvl_w(DEPTH)-1:0]    level,
   output logic                       afull,
   output logic                       ovf,
   input  logic                       ovf_clr
`ifdef SIG_BUF_OVF_CNT_EN
   ,output logic [OVF_CNT_W-1:0]      ovf_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = lvl_w(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] level_q, level_d;
   logic          afull_q, afull_d;
   logic          ovf_q, ovf_d;
   logic          empty, full, pop, wr_ok, drop;
   logic [WIDTH-1:0] rdata;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && bus.sig_out_rdy;
   // A pop frees the head slot this cycle, so a write into a full buffer still lands.
   assign wr_ok = bus.sig_in_vld && (!full || pop);
   assign drop  = bus.sig_in_vld && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_ok, pop})
         2'b10:   level_d = level_q + PW'(1);
         2'b01:   level_d = level_q - PW'(1);
         default: level_d = level_q;
      endcase
      afull_d = (level_d >= PW'(AFULL_LVL));
      ovf_d   = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef SIG_BUF_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

   // A clear coinciding with a drop restarts the count at one rather than losing the drop.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_clr)
         ovf_cnt_d = drop ? OVF_CNT_W'(1) : '0;
      else if (drop && (ovf_cnt_q != '1))
         ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ovf_cnt_q <= '0;
      else       ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

   sig_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_ok),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (bus.sig_in),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rdata)
   );

   assign bus.sig_out_vld = !empty;
   assign bus.sig_out     = empty ? '0 : rdata;
   assign level           = level_q;
   assign afull           = afull_q;
   assign ovf             = ovf_q;

endmodule

// File: tb/tb_sig_buf.sv
// Randomized and directed bench for sig_buf against a queue-based reference model.
module tb_sig_buf;
   import sig_pkg::*;

   localparam int WIDTH     = 8;
   localparam int DEPTH     = 4;
   localparam int AFULL_LVL = DEPTH - 1;
   localparam int LW        = lvl_w(DEPTH);

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [LW-1:0] level;
   logic          afull;
   logic          ovf;
`ifdef SIG_BUF_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt;
   int                   m_cnt = 0;
`endif

   sig_buf_if #(.WIDTH(WIDTH)) bus ();

   sig_buf #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .bus     (bus),
      .level   (level),
      .afull   (afull),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
`ifdef SIG_BUF_OVF_CNT_EN
      ,.ovf_cnt (ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_wr   = 0;

   logic [WIDTH-1:0] mq[$];
   bit               m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      int sz;
      sz = mq.size();
      chk({tag, "_vld"},   32'(bus.sig_out_vld), 32'(sz != 0));
      chk({tag, "_out"},   32'(bus.sig_out),     (sz != 0) ? 32'(mq[0]) : 32'd0);
      chk({tag, "_level"}, 32'(level),           32'(sz));
      chk({tag, "_afull"}, 32'(afull),           32'(sz >= AFULL_LVL));
      chk({tag, "_ovf"},   32'(ovf),             32'(m_ovf));
`ifdef SIG_BUF_OVF_CNT_EN
      chk({tag, "_cnt"},   32'(ovf_cnt),         32'(m_cnt));
`endif
   endtask

   // Apply one cycle of stimulus, advance the model by the buffer's rules, then check.
   task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic clr);
      int sz;
      bit pop, wr, drop;
      bus.sig_in_vld  = v;
      bus.sig_in      = d;
      bus.sig_out_rdy = r;
      ovf_clr         = clr;
      sz   = mq.size();
      pop  = (sz > 0) && r;
      wr   = v && ((sz < DEPTH) || pop);
      drop = v && !wr;
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (wr) begin
         mq.push_back(d);
         n_wr++;
      end
      m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
`ifdef SIG_BUF_OVF_CNT_EN
      if (clr)       m_cnt = drop ? 1 : 0;
      else if (drop) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
`endif
      #1;
      chk_model(tag);
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
`ifdef SIG_BUF_OVF_CNT_EN
      m_cnt = 0;
`endif
   endtask

   task automatic do_reset();
      bus.sig_in_vld  = 1'b0;
      bus.sig_in      = '0;
      bus.sig_out_rdy = 1'b0;
      ovf_clr         = 1'b0;
      rstn = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      logic [WIDTH-1:0] exp_list[$];
      bus.sig_in_vld  = 1'b0;
      bus.sig_in      = '0;
      bus.sig_out_rdy = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld",   32'(bus.sig_out_vld), 32'd0);
      chk("rst_out",   32'(bus.sig_out),     32'd0);
      chk("rst_level", 32'(level),           32'd0);
      chk("rst_afull", 32'(afull),           32'd0);
      chk("rst_ovf",   32'(ovf),             32'd0);
      rstn = 1'b1;

      // Fall-through of a single word, no same-cycle pass-through.
      chk("ft_pre_vld", 32'(bus.sig_out_vld), 32'd0);
      step("ft_wr", 1'b1, 8'h01, 1'b1, 1'b0);
      chk("ft_vld", 32'(bus.sig_out_vld), 32'd1);
      chk("ft_out", 32'(bus.sig_out),     32'h01);
      step("ft_pop", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("ft_empty_level", 32'(level), 32'd0);

      // Fill past full with no reader: fifth write is lost.
      do_reset();
      foreach (exp_list[i]) exp_list.delete(i);
      exp_list = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
      for (int i = 0; i < 5; i++) step("ovf_fill", 1'b1, 8'(8'h0A + i), 1'b0, 1'b0);
      chk("ovf_level", 32'(level), 32'd4);
      chk("ovf_afull", 32'(afull), 32'd1);
      chk("ovf_flag",  32'(ovf),   32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain", 32'(bus.sig_out), 32'(exp_list[i]));
         step("ovf_drain_st", 1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("ovf_lost_level", 32'(level), 32'd0);

      // Write with simultaneous pop while full is accepted.
      do_reset();
      for (int i = 1; i <= 4; i++) step("fp_fill", 1'b1, 8'(i), 1'b0, 1'b0);
      step("fp_wr", 1'b1, 8'h05, 1'b1, 1'b0);
      chk("fp_level", 32'(level), 32'd4);
      chk("fp_ovf",   32'(ovf),   32'd0);
      for (int i = 2; i <= 5; i++) begin
         chk("fp_drain", 32'(bus.sig_out), 32'(i));
         step("fp_drain_st", 1'b0, 8'h00, 1'b1, 1'b0);
      end

`ifdef SIG_BUF_OVF_CNT_EN
      // Dropped-write counter, clear coinciding with a fourth drop.
      do_reset();
      for (int i = 0; i < 4; i++) step("cnt_fill", 1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("cnt_drop", 1'b1, 8'hEE, 1'b0, 1'b0);
      chk("cnt_three", 32'(ovf_cnt), 32'd3);
      step("cnt_clr", 1'b1, 8'hEF, 1'b0, 1'b1);
      chk("cnt_one",     32'(ovf_cnt), 32'd1);
      chk("cnt_ovf_set", 32'(ovf),     32'd1);
      step("cnt_clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
      chk("cnt_cleared", 32'(ovf_cnt), 32'd0);
`endif

      // Random traffic; the producer holds off while the model says a write would drop.
      do_reset();
      n_wr = 0;
      for (int c = 0; c < 1000; c++) begin
         logic v, r;
         r = ($urandom_range(0, 99) < 80);
         v = ($urandom_range(0, 99) < 60);
         if ((mq.size() >= DEPTH) && !r) v = 1'b0;
         step("rnd", v, 8'($urandom), r, 1'b0);
      end
      chk("rnd_no_ovf", 32'(ovf), 32'd0);
      chk("rnd_wraps",  32'(n_wr / DEPTH >= 100), 32'd1);

      // Asynchronous reset mid-operation with three entries held.
      do_reset();
      for (int i = 0; i < 3; i++) step("ar_fill", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      chk("ar_pre_level", 32'(level), 32'd3);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      chk("ar_vld",   32'(bus.sig_out_vld), 32'd0);
      chk("ar_level", 32'(level),           32'd0);
      chk("ar_out",   32'(bus.sig_out),     32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step("ar_wr", 1'b1, 8'h77, 1'b0, 1'b0);
      chk("ar_head", 32'(bus.sig_out), 32'h77);
      step("ar_drain", 1'b0, 8'h00, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
